// File: rtl/rocc_accel_responder.sv
// Accelerator end of the RoCC link: an 8-bit accumulator driven by RoCC commands, with memory requests and results.
// Optional build macro ROCC_ACCEL_PERF_CNT_EN adds a saturating completed-command counter read by funct 4/5.
module rocc_accel_responder #(
    parameter int CMD_WIDTH      = 16,
    parameter int RESP_WIDTH     = 8,
    parameter int MEM_REQ_WIDTH  = 32,
    parameter int MEM_RESP_WIDTH = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      rocc_cmd_v_i,
    input  logic [CMD_WIDTH-1:0]      rocc_cmd_data_i,
    output logic                      rocc_cmd_ready_o,
    output logic                      rocc_resp_v_o,
    output logic [RESP_WIDTH-1:0]     rocc_resp_data_o,
    input  logic                      rocc_resp_ready_i,
    output logic                      rocc_mem_req_v_o,
    output logic [MEM_REQ_WIDTH-1:0]  rocc_mem_req_data_o,
    input  logic                      rocc_mem_req_ready_i,
    input  logic                      rocc_mem_resp_v_i,
    input  logic [MEM_RESP_WIDTH-1:0] rocc_mem_resp_data_i,
    input  logic                      rocc_ctrl_i_exception_,
    output logic                      rocc_ctrl_o_busy_,
    output logic                      rocc_ctrl_o_interrupt_,
    output logic [1:0]                dbg_state_o
);

    // Handshakes: a valid/ready pair transfers on a clk_i edge where both are high. A raised valid keeps
    // its data stable and drops only after that transfer, an exception, or reset. Memory responses have
    // no ready: one is taken on the first cycle mem_resp_v is high in MEM_WAIT and ignored otherwise.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [RESP_WIDTH-1:0]    acc_q, acc_d;
    logic [RESP_WIDTH-1:0]    resp_q, resp_d;
    logic [MEM_REQ_WIDTH-1:0] req_q, req_d;
    logic                     load_q, load_d;
    logic                     xd_q, xd_d;
    logic                     intr_q, intr_d;
    logic                     busy_q;
    logic                     fin;
    logic [RESP_WIDTH-1:0]    fin_data;

    logic [3:0] funct;
    logic       cmd_xd;
    logic [7:0] imm;
    logic       unused_bits;

    assign funct       = rocc_cmd_data_i[15:12];
    assign cmd_xd      = rocc_cmd_data_i[11];
    assign imm         = rocc_cmd_data_i[7:0];
    assign unused_bits = ^{rocc_cmd_data_i[10:8], rocc_mem_resp_data_i[MEM_RESP_WIDTH-1:RESP_WIDTH]};

`ifdef ROCC_ACCEL_PERF_CNT_EN
    logic [15:0] cnt_q;
    logic        cnt_skip;
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        resp_d   = resp_q;
        req_d    = req_q;
        load_d   = load_q;
        xd_d     = xd_q;
        intr_d   = intr_q;
        fin      = 1'b0;
        fin_data = resp_q;
`ifdef ROCC_ACCEL_PERF_CNT_EN
        cnt_skip = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (rocc_cmd_v_i) begin
                    xd_d   = cmd_xd;
                    intr_d = 1'b0;
                    case (funct)
                        4'd0: begin
                            acc_d    = acc_q + imm;
                            fin      = 1'b1;
                            fin_data = acc_q + imm;
                        end
                        4'd1: begin
                            load_d  = 1'b1;
                            req_d   = {1'b0, 7'b0, acc_q, imm, 8'h00};
                            state_d = MEM_REQ;
                        end
                        4'd2: begin
                            load_d  = 1'b0;
                            req_d   = {1'b1, 7'b0, 8'h00, imm, acc_q};
                            state_d = MEM_REQ;
                        end
                        4'd3: begin
                            acc_d    = imm;
                            fin      = 1'b1;
                            fin_data = imm;
                        end
`ifdef ROCC_ACCEL_PERF_CNT_EN
                        4'd4: begin
                            fin      = 1'b1;
                            fin_data = cnt_q[7:0];
                            cnt_skip = 1'b1;
                        end
                        4'd5: begin
                            fin      = 1'b1;
                            fin_data = cnt_q[15:8];
                        end
`endif
                        default: intr_d = 1'b1;
                    endcase
                end
            end
            MEM_REQ: begin
                if (rocc_ctrl_i_exception_)    state_d = IDLE;
                else if (rocc_mem_req_ready_i) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                // An abort here wins over a same-cycle memory response, so acc is left untouched.
                if (rocc_ctrl_i_exception_) begin
                    state_d = IDLE;
                end else if (rocc_mem_resp_v_i) begin
                    fin = 1'b1;
                    if (load_q) begin
                        acc_d    = rocc_mem_resp_data_i[RESP_WIDTH-1:0];
                        fin_data = rocc_mem_resp_data_i[RESP_WIDTH-1:0];
                    end else begin
                        fin_data = acc_q;
                    end
                end
            end
            RESP: begin
                if (rocc_ctrl_i_exception_ || rocc_resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (fin) begin
            resp_d  = fin_data;
            state_d = xd_d ? RESP : IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            resp_q  <= '0;
            req_q   <= '0;
            load_q  <= 1'b0;
            xd_q    <= 1'b0;
            intr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            resp_q  <= resp_d;
            req_q   <= req_d;
            load_q  <= load_d;
            xd_q    <= xd_d;
            intr_q  <= intr_d;
            busy_q  <= (state_d != IDLE);
        end
    end

`ifdef ROCC_ACCEL_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else if (fin && !cnt_skip && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end
`endif

    assign rocc_cmd_ready_o       = (state_q == IDLE);
    assign rocc_resp_v_o          = (state_q == RESP);
    assign rocc_resp_data_o       = resp_q;
    assign rocc_mem_req_v_o       = (state_q == MEM_REQ);
    assign rocc_mem_req_data_o    = req_q;
    assign rocc_ctrl_o_busy_      = busy_q;
    assign rocc_ctrl_o_interrupt_ = intr_q;
    // 0 IDLE, 1 MEM_REQ, 2 MEM_WAIT, 3 RESP
    assign dbg_state_o            = state_q;

endmodule

// File: tb/tb_rocc_accel_responder.sv
// Self-checking bench for rocc_accel_responder: directed pins plus random commands against a
// transaction-level model of the accumulator, memory traffic and response order.
module tb_rocc_accel_responder;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        rocc_cmd_v_i;
    logic [15:0] rocc_cmd_data_i;
    logic        rocc_cmd_ready_o;
    logic        rocc_resp_v_o;
    logic [7:0]  rocc_resp_data_o;
    logic        rocc_resp_ready_i;
    logic        rocc_mem_req_v_o;
    logic [31:0] rocc_mem_req_data_o;
    logic        rocc_mem_req_ready_i;
    logic        rocc_mem_resp_v_i;
    logic [63:0] rocc_mem_resp_data_i;
    logic        rocc_ctrl_i_exception_;
    logic        rocc_ctrl_o_busy_;
    logic        rocc_ctrl_o_interrupt_;
    logic [1:0]  dbg_state_o;

    always #5 clk_i = ~clk_i;

    rocc_accel_responder dut (
        .clk_i                 (clk_i),
        .reset_i               (reset_i),
        .rocc_cmd_v_i          (rocc_cmd_v_i),
        .rocc_cmd_data_i       (rocc_cmd_data_i),
        .rocc_cmd_ready_o      (rocc_cmd_ready_o),
        .rocc_resp_v_o         (rocc_resp_v_o),
        .rocc_resp_data_o      (rocc_resp_data_o),
        .rocc_resp_ready_i     (rocc_resp_ready_i),
        .rocc_mem_req_v_o      (rocc_mem_req_v_o),
        .rocc_mem_req_data_o   (rocc_mem_req_data_o),
        .rocc_mem_req_ready_i  (rocc_mem_req_ready_i),
        .rocc_mem_resp_v_i     (rocc_mem_resp_v_i),
        .rocc_mem_resp_data_i  (rocc_mem_resp_data_i),
        .rocc_ctrl_i_exception_(rocc_ctrl_i_exception_),
        .rocc_ctrl_o_busy_     (rocc_ctrl_o_busy_),
        .rocc_ctrl_o_interrupt_(rocc_ctrl_o_interrupt_),
        .dbg_state_o           (dbg_state_o)
    );

    int total = 0;
    int bad   = 0;

    // Model: architectural accumulator/flags, which phase a command is in, and the response queue.
    logic [7:0]  m_acc  = 8'h00;
    logic        m_intr = 1'b0;
    logic [15:0] m_cnt  = 16'h0000;
    logic        e_req  = 1'b0;
    logic        e_wait = 1'b0;
    logic        e_resp = 1'b0;
    logic [31:0] e_req_data = 32'h0;
    logic [7:0]  exp_q[$];
    logic        checking = 1'b0;
    logic [31:0] seen_req;
    logic [7:0]  seen_resp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (checking) begin
            logic any;
            any = e_req | e_wait | e_resp;
            chk("cmd_ready", rocc_cmd_ready_o, !any);
            chk("busy", rocc_ctrl_o_busy_, any);
            chk("dbg_idle", dbg_state_o == 2'd0, !any);
            chk("interrupt", rocc_ctrl_o_interrupt_, m_intr);
            chk("resp_v", rocc_resp_v_o, e_resp);
            chk("mem_req_v", rocc_mem_req_v_o, e_req);
            if (rocc_mem_req_v_o && e_req) begin
                chk("mem_req_data", rocc_mem_req_data_o, e_req_data);
                seen_req = rocc_mem_req_data_o;
            end
            if (rocc_resp_v_o && e_resp && exp_q.size() != 0) begin
                chk("resp_data", rocc_resp_data_o, exp_q[0]);
                seen_resp = rocc_resp_data_o;
                if (rocc_resp_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    function automatic bit is_legal(input logic [3:0] f);
`ifdef ROCC_ACCEL_PERF_CNT_EN
        return f <= 4'd5;
`else
        return f <= 4'd3;
`endif
    endfunction

    // exc_at: 0 none, 1 abort in MEM_REQ, 2 abort in MEM_WAIT, 3 abort in RESP.
    task automatic issue(input logic [3:0] funct, input logic xd, input logic [7:0] imm,
                         input logic [7:0] mem_byte, input int req_stall, input int wait_cyc,
                         input int resp_stall, input int exc_at);
        logic [7:0] res;
        bit         is_mem;
        res = 8'h00;
        rocc_cmd_v_i    = 1'b1;
        rocc_cmd_data_i = {funct, xd, 3'($urandom), imm};
        tick();
        rocc_cmd_v_i    = 1'b0;
        rocc_cmd_data_i = 16'($urandom);
        if (!is_legal(funct)) begin
            m_intr = 1'b1;
            return;
        end
        m_intr = 1'b0;
        is_mem = (funct == 4'd1) || (funct == 4'd2);
        case (funct)
            4'd0: begin m_acc = m_acc + imm; res = m_acc; end
            4'd1: e_req_data = {8'h00, m_acc, imm, 8'h00};
            4'd2: e_req_data = {8'h80, 8'h00, imm, m_acc};
            4'd3: begin m_acc = imm; res = imm; end
            4'd4: res = m_cnt[7:0];
            default: res = m_cnt[15:8];
        endcase
        if (is_mem) begin
            e_req = 1'b1;
            if (exc_at == 1) begin
                rocc_ctrl_i_exception_ = 1'b1;
                tick();
                rocc_ctrl_i_exception_ = 1'b0;
                e_req = 1'b0;
                return;
            end
            for (int i = 0; i < req_stall; i++) begin
                rocc_mem_resp_v_i    = 1'($urandom_range(0, 1));
                rocc_mem_resp_data_i = {$urandom, $urandom};
                tick();
            end
            rocc_mem_resp_v_i    = 1'b0;
            rocc_mem_req_ready_i = 1'b1;
            tick();
            rocc_mem_req_ready_i = 1'b0;
            e_req  = 1'b0;
            e_wait = 1'b1;
            for (int i = 0; i < wait_cyc; i++) tick();
            if (exc_at == 2) begin
                rocc_ctrl_i_exception_ = 1'b1;
                tick();
                rocc_ctrl_i_exception_ = 1'b0;
                e_wait = 1'b0;
                return;
            end
            rocc_mem_resp_v_i    = 1'b1;
            rocc_mem_resp_data_i = {$urandom, 24'($urandom), mem_byte};
            tick();
            rocc_mem_resp_v_i = 1'b0;
            e_wait = 1'b0;
            if (funct == 4'd1) m_acc = mem_byte;
            res = m_acc;
        end
        if (funct != 4'd4 && m_cnt != 16'hFFFF) m_cnt++;
        if (!xd) return;
        exp_q.push_back(res);
        e_resp = 1'b1;
        if (exc_at == 3) begin
            rocc_ctrl_i_exception_ = 1'b1;
            tick();
            rocc_ctrl_i_exception_ = 1'b0;
            e_resp = 1'b0;
            exp_q.delete();
            return;
        end
        for (int i = 0; i < resp_stall; i++) begin
            rocc_mem_resp_v_i    = 1'($urandom_range(0, 1));
            rocc_mem_resp_data_i = {$urandom, $urandom};
            tick();
        end
        rocc_mem_resp_v_i = 1'b0;
        rocc_resp_ready_i = 1'b1;
        tick();
        rocc_resp_ready_i = 1'b0;
        e_resp = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            rocc_mem_resp_v_i      = 1'($urandom_range(0, 1));
            rocc_mem_resp_data_i   = {$urandom, $urandom};
            rocc_ctrl_i_exception_ = ($urandom_range(0, 3) == 0);
            tick();
        end
        rocc_mem_resp_v_i      = 1'b0;
        rocc_ctrl_i_exception_ = 1'b0;
    endtask

    task automatic model_reset();
        m_acc  = 8'h00;
        m_intr = 1'b0;
        m_cnt  = 16'h0000;
        e_req  = 1'b0;
        e_wait = 1'b0;
        e_resp = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        reset_i                = 1'b0;
        rocc_cmd_v_i           = 1'b0;
        rocc_cmd_data_i        = 16'h0;
        rocc_resp_ready_i      = 1'b0;
        rocc_mem_req_ready_i   = 1'b0;
        rocc_mem_resp_v_i      = 1'b0;
        rocc_mem_resp_data_i   = 64'h0;
        rocc_ctrl_i_exception_ = 1'b0;
        tick();
        checking = 1'b1;
        chk("rst_resp_data", rocc_resp_data_o, 32'h0);
        chk("rst_req_data", rocc_mem_req_data_o, 32'h0);
        tick();
        reset_i = 1'b1;
        tick();

        // SET then wrapping ADD
        seen_resp = 'x;
        issue(4'd3, 1'b1, 8'h10, 8'h00, 0, 0, 0, 0);
        chk("pin_set", seen_resp, 32'h10);
        seen_resp = 'x;
        issue(4'd0, 1'b1, 8'hF5, 8'h00, 0, 0, 1, 0);
        chk("pin_add_wrap", seen_resp, 32'h05);

        // LOAD with a stalled request
        issue(4'd3, 1'b0, 8'h12, 8'h00, 0, 0, 0, 0);
        seen_req = 'x;
        seen_resp = 'x;
        issue(4'd1, 1'b1, 8'h34, 8'hAB, 3, 1, 0, 0);
        chk("pin_load_req", seen_req, 32'h0012_3400);
        chk("pin_load_resp", seen_resp, 32'hAB);
        seen_resp = 'x;
        issue(4'd0, 1'b1, 8'h00, 8'h00, 0, 0, 0, 0);
        chk("pin_acc_after_load", seen_resp, 32'hAB);

        // STORE without a response
        issue(4'd3, 1'b0, 8'h5A, 8'h00, 0, 0, 0, 0);
        seen_req = 'x;
        issue(4'd2, 1'b0, 8'h07, 8'h99, 0, 2, 0, 0);
        chk("pin_store_req", seen_req, 32'h8000_075A);
        chk("pin_store_ready", rocc_cmd_ready_o, 1'b1);

        // illegal command, cleared by a legal one
        issue(4'hF, 1'b1, 8'h00, 8'h00, 0, 0, 0, 0);
        chk("pin_intr_set", rocc_ctrl_o_interrupt_, 1'b1);
        tick();
        issue(4'd0, 1'b0, 8'h01, 8'h00, 0, 0, 0, 0);
        chk("pin_intr_clear", rocc_ctrl_o_interrupt_, 1'b0);

        // LOAD aborted in MEM_WAIT, then a stray memory response
        issue(4'd3, 1'b0, 8'h33, 8'h00, 0, 0, 0, 0);
        issue(4'd1, 1'b1, 8'h01, 8'hEE, 0, 1, 0, 2);
        rocc_mem_resp_v_i    = 1'b1;
        rocc_mem_resp_data_i = 64'h0000_0000_0000_00EE;
        tick();
        rocc_mem_resp_v_i = 1'b0;
        seen_resp = 'x;
        issue(4'd0, 1'b1, 8'h00, 8'h00, 0, 0, 0, 0);
        chk("pin_abort_acc", seen_resp, 32'h33);

        // reset while a response is stalled
        rocc_cmd_v_i    = 1'b1;
        rocc_cmd_data_i = {4'd3, 1'b1, 3'b0, 8'h77};
        tick();
        rocc_cmd_v_i = 1'b0;
        m_acc  = 8'h77;
        m_intr = 1'b0;
        if (m_cnt != 16'hFFFF) m_cnt++;
        exp_q.push_back(8'h77);
        e_resp = 1'b1;
        tick();
        reset_i = 1'b0;
        tick();
        model_reset();
        chk("pin_rst_resp_v", rocc_resp_v_o, 1'b0);
        chk("pin_rst_busy", rocc_ctrl_o_busy_, 1'b0);
        reset_i = 1'b1;
        tick();
        seen_resp = 'x;
        issue(4'd0, 1'b1, 8'h00, 8'h00, 0, 0, 0, 0);
        chk("pin_rst_acc", seen_resp, 32'h00);

`ifdef ROCC_ACCEL_PERF_CNT_EN
        reset_i = 1'b0;
        tick();
        model_reset();
        reset_i = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) issue(4'd3, 1'b0, 8'(i), 8'h00, 0, 0, 0, 0);
        seen_resp = 'x;
        issue(4'd4, 1'b1, 8'h00, 8'h00, 0, 0, 0, 0);
        chk("pin_cnt", seen_resp, 32'h03);
`endif

        for (int n = 0; n < 200; n++) begin
            int         r;
            int         exc;
            logic [3:0] f;
            r   = $urandom_range(0, 11);
            f   = (r < 9) ? 4'(r % 4) : 4'($urandom_range(4, 15));
            exc = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            issue(f, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), exc);
            idle_cycles($urandom_range(0, 2));
        end

        tick();
        chk("exp_q_empty", exp_q.size(), 32'h0);
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
